// File: rtl/sar_search.sv
// Successive-approximation search controller: drives a probe into a magnitude
// comparator and binary-searches the comparator's other operand via its flags.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             less,
    input  logic             equal,
    input  logic             bigger,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             error
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [1:0]       state;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    logic [2:0]       flags;
    logic             one_hot;
    logic             finish;
    logic [WIDTH-1:0] probe_inc;
    logic [WIDTH-1:0] probe_dec;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_sum;

    // Sums are one bit wider than the operands so the midpoint never wraps.
    always_comb begin
        flags     = {less, equal, bigger};
        one_hot   = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
        finish    = !one_hot || equal || (bigger && probe == hi) || (less && probe == lo);
        probe_inc = probe + ONE;
        probe_dec = probe - ONE;
        up_sum    = {1'b0, probe_inc} + {1'b0, hi};
        dn_sum    = {1'b0, lo} + {1'b0, probe_dec};
    end

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            state  <= IDLE;
            probe  <= '0;
            busy   <= 1'b0;
            result <= '0;
            error  <= 1'b0;
            lo     <= '0;
            hi     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lo    <= '0;
                        hi    <= '1;
                        // (0 + all-ones) >> 1
                        probe <= {1'b0, {(WIDTH-1){1'b1}}};
                        busy  <= 1'b1;
                        error <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: state <= SAMPLE;
                SAMPLE: begin
                    if (finish) begin
                        result <= probe;
                        error  <= !(one_hot && equal);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (bigger) begin
                        lo    <= probe_inc;
                        probe <= WIDTH'(up_sum >> 1);
                        state <= WAIT;
                    end else begin
                        hi    <= probe_dec;
                        probe <= WIDTH'(dn_sum >> 1);
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: a comparator stub plus a search-schedule model
// checked against the DUT every cycle, with literal expectations from hand analysis.
module tb_sar_search;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         less, equal, bigger;
    logic [W-1:0] probe, result;
    logic         busy, done, error;

    int           target = 0;
    int           mode = 0;      // 0: real comparator, 1: forced flags, 2: always bigger
    logic [2:0]   forced = 3'b000;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sar_search #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .less   (less),
        .equal  (equal),
        .bigger (bigger),
        .probe  (probe),
        .busy   (busy),
        .done   (done),
        .result (result),
        .error  (error)
    );

    function automatic logic [2:0] flags_for(input int md, input int tgt, input logic [2:0] frc, input int p);
        if (md == 1) return frc;
        if (md == 2) return 3'b001;
        if (tgt < p) return 3'b100;
        if (tgt == p) return 3'b010;
        return 3'b001;
    endfunction

    always_comb {less, equal, bigger} = flags_for(mode, target, forced, int'(probe));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Search model: the full probe sequence and outcome are planned at start,
    // then outputs follow from the number of edges since the start edge.
    int seq[8];
    int n = 0;
    int c = 0;
    int s_res = 0;
    int s_err = 0;
    bit m_active = 0;
    bit m_done = 0;
    int m_error = 0;
    int m_result = 0;
    int m_probe_hold = 0;

    task automatic plan();
        int lo, hi, p;
        bit fin;
        logic [2:0] f;
        lo = 0; hi = (1 << W) - 1; n = 0; fin = 0;
        while (!fin && n < 8) begin
            p = (lo + hi) / 2;
            seq[n] = p;
            n++;
            f = flags_for(mode, target, forced, p);
            if (!(f == 3'b100 || f == 3'b010 || f == 3'b001)) begin
                s_res = p; s_err = 1; fin = 1;
            end else if (f == 3'b010) begin
                s_res = p; s_err = 0; fin = 1;
            end else if ((f == 3'b001 && p == hi) || (f == 3'b100 && p == lo)) begin
                s_res = p; s_err = 1; fin = 1;
            end else if (f == 3'b001) begin
                lo = p + 1;
            end else begin
                hi = p - 1;
            end
        end
    endtask

    always @(posedge clk) begin
        m_done = 0;
        if (rst) begin
            m_active = 0; m_probe_hold = 0; m_result = 0; m_error = 0;
        end else if (!m_active && start) begin
            plan();
            m_active = 1; c = 0; m_error = 0;
        end else if (m_active) begin
            c++;
            if (c == 2 * n) begin
                m_active = 0; m_done = 1;
                m_result = s_res; m_error = s_err; m_probe_hold = seq[n-1];
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_active));
        chk("done", int'(done), int'(m_done));
        chk("probe", int'(probe), m_active ? seq[c/2] : m_probe_hold);
        chk("result", int'(result), m_result);
        chk("error", int'(error), m_error);
    end

    int probes[$];

    task automatic run_search(input int tgt, input int md, input logic [2:0] frc, input bit now,
                              input bit hold, output int cyc, output int res, output int err);
        target = tgt; mode = md; forced = frc;
        if (!now) @(negedge clk);
        start = 1'b1;
        probes.delete();
        @(negedge clk);
        if (!hold) start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            if (probes.size() == 0 || probes[$] != int'(probe)) probes.push_back(int'(probe));
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 40) chk("done_timeout", cyc, 0);
        res = int'(result);
        err = int'(error);
    endtask

    task automatic chk_seq(input string name, input int e0, input int e1, input int e2,
                           input int e3, input int e4, input int len);
        int exp[5];
        exp = '{e0, e1, e2, e3, e4};
        chk({name, "_len"}, probes.size(), len);
        for (int i = 0; i < len && i < probes.size(); i++)
            chk(name, probes[i], exp[i]);
    endtask

    int cyc, res, err;
    bit saw_done;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_probe", int'(probe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        rst = 1'b0;

        run_search(7, 0, 3'b000, 0, 0, cyc, res, err);
        chk("t7_cycles", cyc, 2);
        chk("t7_result", res, 7);
        chk("t7_error", err, 0);
        chk_seq("t7_probes", 7, 0, 0, 0, 0, 1);

        run_search(15, 0, 3'b000, 0, 0, cyc, res, err);
        chk("t15_cycles", cyc, 10);
        chk("t15_result", res, 15);
        chk("t15_error", err, 0);
        chk_seq("t15_probes", 7, 11, 13, 14, 15, 5);

        run_search(0, 0, 3'b000, 0, 0, cyc, res, err);
        chk("t0_cycles", cyc, 8);
        chk("t0_result", res, 0);
        chk_seq("t0_probes", 7, 3, 1, 0, 0, 4);

        for (int t = 0; t < 16; t++) begin
            run_search(t, 0, 3'b000, 0, 0, cyc, res, err);
            chk("sweep_result", res, t);
            chk("sweep_error", err, 0);
            chk("sweep_len_ok", int'(cyc <= 10 && cyc >= 2), 1);
        end

        run_search(9, 1, 3'b000, 0, 0, cyc, res, err);
        chk("f000_cycles", cyc, 2);
        chk("f000_result", res, 7);
        chk("f000_error", err, 1);

        run_search(9, 1, 3'b110, 0, 0, cyc, res, err);
        chk("f110_cycles", cyc, 2);
        chk("f110_result", res, 7);
        chk("f110_error", err, 1);

        run_search(0, 2, 3'b000, 0, 0, cyc, res, err);
        chk("big_cycles", cyc, 10);
        chk("big_result", res, 15);
        chk("big_error", err, 1);
        chk_seq("big_probes", 7, 11, 13, 14, 15, 5);

        // reset sampled at edge 5 of a search that would end at edge 8
        target = 0; mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_probe", int'(probe), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_error", int'(error), 0);
        chk("midrst_done", int'(done), 0);
        rst = 1'b0;
        saw_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        chk("midrst_no_done", int'(saw_done), 0);

        run_search(5, 0, 3'b000, 0, 1, cyc, res, err);
        chk("hold_result", res, 5);
        chk("hold_cycles", cyc, 6);
        repeat (3) @(negedge clk);
        chk("hold_no_restart", int'(busy), 0);

        run_search(3, 0, 3'b000, 0, 0, cyc, res, err);
        chk("b2b_first_result", res, 3);
        run_search(12, 0, 3'b000, 1, 0, cyc, res, err);
        chk("b2b_second_result", res, 12);
        chk("b2b_second_cycles", cyc, 8);
        chk_seq("b2b_probes", 7, 11, 13, 12, 0, 4);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller that drives the probe operand of the 4-bit magnitude comparator and reads back its less/equal/bigger flags. It binary-searches for the unknown value on the comparator's other operand. On a start request it issues probes, narrows a [lo, hi] bound on each comparator answer, and returns the value found or an error. It sits beside the comparator as its initiator: probe connects to the comparator's in2, the unknown value drives in1, and the flags return here.

## Interface
Parameters:
- WIDTH, 4: operand width; search range is 0 .. 2^WIDTH-1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request a new search; sampled only in IDLE.
- less  in  1  comparator flag: target < probe.
- equal  in  1  comparator flag: target == probe.
- bigger  in  1  comparator flag: target > probe.
- probe  out  WIDTH  registered probe value to the comparator.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when a search ends.
- result  out  WIDTH  value found, or the last probe on error; held until the next accepted start.
- error  out  1  search ended abnormally; valid with done and held until the next accepted start.

## Operation
- States: IDLE, WAIT, SAMPLE.
- Internal bounds lo and hi are WIDTH bits wide.
- IDLE, start=1:
  - lo=0, hi=2^WIDTH-1, probe=(lo+hi)>>1 (7 for WIDTH=4).
  - busy=1, error=0 -> WAIT.
  - start=0 leaves all outputs held.
- WAIT: no action; gives the comparator a full cycle to settle on the new probe -> SAMPLE.
- SAMPLE: evaluate the flags.
  - Flags not one-hot (none or several high): result=probe, error=1, done=1, busy=0 -> IDLE.
  - equal: result=probe, error=0, done=1, busy=0 -> IDLE.
  - bigger with probe==hi, or less with probe==lo: the target is outside the bounds. result=probe, error=1, done=1, busy=0 -> IDLE.
  - bigger otherwise: lo=probe+1, probe=(probe+1+hi)>>1 -> WAIT.
  - less otherwise: hi=probe-1, probe=(lo+probe-1)>>1 -> WAIT.
- The sum lo+hi is computed WIDTH+1 bits wide before the shift, so it never wraps.
- The guard conditions make lo+1 and hi-1 wrap-free.
- start while busy is ignored.
- done is deasserted in every cycle other than the end pulse.

## Timing
- Reset values: state=IDLE, probe=0, busy=0, done=0, result=0, error=0, lo=0, hi=0.
- rst mid-search aborts the search on the next edge with no done pulse.
- Each comparison costs 2 cycles (WAIT + SAMPLE).
- A search makes N comparisons, 1 <= N <= WIDTH+1.
- With start sampled at edge 0, done is high during the cycle after edge 2N.
- Flags are sampled only in SAMPLE; flag changes at any other time have no effect.
- The done cycle is an IDLE cycle. A start in that cycle is accepted: busy rises at the next edge and done drops.

## Test plan
- Target 7 (WIDTH=4), start at edge 0 -> probe=7, done at edge 2, result=7, error=0, N=1.
- Target 15 -> probe sequence 7, 11, 13, 14, 15; done after edge 10, result=15, error=0.
- Target 0 -> probe sequence 7, 3, 1, 0; done after edge 8, result=0. Repeat the sweep for all 16 targets: result equals target, N <= 5.
- Force flags to 000 in the first SAMPLE -> done after edge 2, error=1, result=7. Force 110 -> same outcome.
- Fake comparator answering bigger at every probe -> probes 7, 11, 13, 14, 15, then error=1 with result=15.
- Control cases:
  - rst asserted at edge 5 mid-search -> all outputs at reset values after edge 5, no done pulse.
  - start held high during busy -> no restart.
  - start pulsed in the done cycle -> new search begins.
